// File: rtl/spi_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_frame_rx: SPI mode-0 slave receiver with CS_n framing and status TX  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module spi_frame_rx #(
  parameter int FRAME_BYTES = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysClk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] status_byte,
  output logic [7:0] spi_byte,
  output logic       spi_input_valid,
  output logic [3:0] spi_byte_num,
  output logic       frame_done,
  output logic       frame_error
);

  localparam int              C_FW     = $clog2(SYNC_STAGES + 2);
  localparam logic [C_FW-1:0] C_SETTLE = C_FW'(SYNC_STAGES + 1);
  localparam logic [4:0]      C_FRAME  = 5'(FRAME_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic                   r_mosi_q;
  logic [C_FW-1:0]        r_settle_cnt;
  logic                   r_sck_rise;
  logic                   r_sck_fall;
  logic                   r_cs_fall;
  logic [2:0]             r_cs_rise_dly;

  logic                   w_settled;
  logic                   w_sck;
  logic                   w_cs;
  logic                   w_cs_rise;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [2:0]             r_bit_cnt;
  logic [4:0]             r_byte_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic                   r_pend;
  logic                   w_overrun;
  logic [4:0]             w_bytes_after;

  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_settled = (r_settle_cnt == C_SETTLE);
  // cs_rise is delayed so a byte finishing alongside it is counted before the frame is judged
  assign w_cs_rise = r_cs_rise_dly[2];

  // Edges are suppressed until the synchronizers hold real input values after reset,
  // so a CS_n already low at reset release does not look like a fresh frame start.
  always_ff @(posedge sysClk) begin
    if (rst) begin
      r_sck_sync    <= '0;
      r_cs_sync     <= '1;
      r_mosi_sync   <= '0;
      r_sck_d       <= 1'b0;
      r_cs_d        <= 1'b1;
      r_mosi_q      <= 1'b0;
      r_settle_cnt  <= '0;
      r_sck_rise    <= 1'b0;
      r_sck_fall    <= 1'b0;
      r_cs_fall     <= 1'b0;
      r_cs_rise_dly <= '0;
    end else begin
      r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d       <= w_sck;
      r_cs_d        <= w_cs;
      r_mosi_q      <= r_mosi_sync[SYNC_STAGES-1];
      if (!w_settled) begin
        r_settle_cnt <= r_settle_cnt + C_FW'(1);
      end
      r_sck_rise    <= w_settled & w_sck & ~r_sck_d;
      r_sck_fall    <= w_settled & ~w_sck & r_sck_d;
      r_cs_fall     <= w_settled & ~w_cs & r_cs_d;
      r_cs_rise_dly <= {r_cs_rise_dly[1:0], w_settled & w_cs & ~r_cs_d};
    end
  end

  assign w_overrun     = r_pend && (r_byte_cnt == C_FRAME);
  assign w_bytes_after = r_byte_cnt + {4'd0, r_pend & ~w_overrun};

  always_ff @(posedge sysClk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_cs_fall) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_cs_rise)      w_state_next = S_IDLE;
        else if (w_overrun) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cs_rise) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      r_bit_cnt       <= 3'd0;
      r_byte_cnt      <= 5'd0;
      r_rx_shift      <= 8'd0;
      r_tx_shift      <= 8'd0;
      r_pend          <= 1'b0;
      spi_byte        <= 8'd0;
      spi_byte_num    <= 4'd0;
      spi_input_valid <= 1'b0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      spi_input_valid <= 1'b0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cs_fall) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 5'd0;
            r_pend     <= 1'b0;
            r_tx_shift <= status_byte;
          end
        end
        S_ACTIVE: begin
          if (r_sck_rise) begin
            r_rx_shift <= {r_rx_shift[6:0], r_mosi_q};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_pend <= 1'b1;
          end
          if (r_sck_fall) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
          if (r_pend) begin
            r_pend <= 1'b0;
            if (w_overrun) begin
              frame_error <= 1'b1;
            end else begin
              spi_byte        <= r_rx_shift;
              spi_byte_num    <= r_byte_cnt[3:0];
              spi_input_valid <= 1'b1;
              r_byte_cnt      <= r_byte_cnt + 5'd1;
            end
          end
          if (w_cs_rise && !w_overrun) begin
            if ((r_bit_cnt == 3'd0) && (w_bytes_after == C_FRAME)) frame_done  <= 1'b1;
            else                                                   frame_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_miso = (r_state == S_ACTIVE) & r_tx_shift[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_spi_frame_rx: scoreboard bench driving SPI frames at sysClk/8 SCK     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_spi_frame_rx;

  localparam int K_BEAT = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int b;
    int n;
  } ev_t;

  logic       sysClk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] status_byte = 8'h00;
  logic       spi_miso;
  logic [7:0] spi_byte;
  logic       spi_input_valid;
  logic [3:0] spi_byte_num;
  logic       frame_done;
  logic       frame_error;

  ev_t exp_q[$];
  int  miso_exp[$];
  int  miso_obs[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic rst_chk = 1'b0;
  logic end_req = 1'b0;

  logic [7:0] f1 [16] = '{8'h03, 8'hA1, 8'h8E, 8'hFE, 8'h6F, 8'hA6, 8'h36, 8'h1A,
                          8'hAE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] f3 [16] = '{8'h11, 8'h22, 8'h33, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] f4 [16] = '{8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h80, 8'h01, 8'h7E, 8'h81,
                          8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] f5 [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  spi_frame_rx #(
    .FRAME_BYTES(9),
    .SYNC_STAGES(2)
  ) dut (
    .sysClk          (sysClk),
    .rst             (rst),
    .spi_sck         (spi_sck),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .status_byte     (status_byte),
    .spi_byte        (spi_byte),
    .spi_input_valid (spi_input_valid),
    .spi_byte_num    (spi_byte_num),
    .frame_done      (frame_done),
    .frame_error     (frame_error)
  );

  always #5 sysClk = ~sysClk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_ev(input int kind, input int b, input int n);
    ev_t e;
    check("sb_has_entry", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == K_BEAT && kind == K_BEAT) begin
        check("spi_byte", b, e.b);
        check("spi_byte_num", n, e.n);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge sysClk) begin
    if (spi_input_valid) chk_ev(K_BEAT, int'(spi_byte), int'(spi_byte_num));
    if (frame_done)      chk_ev(K_DONE, 0, 0);
    if (frame_error)     chk_ev(K_ERR, 0, 0);
    while (miso_obs.size() > 0 && miso_exp.size() > 0) begin
      check("miso_byte", miso_obs.pop_front(), miso_exp.pop_front());
    end
    if (rst_chk) begin
      check("rst_spi_byte", int'(spi_byte), 0);
      check("rst_byte_num", int'(spi_byte_num), 0);
      check("rst_valid", int'(spi_input_valid), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_frame_error", int'(frame_error), 0);
      check("rst_miso", int'(spi_miso), 0);
    end
    if (end_req) begin
      check("sb_drained", exp_q.size(), 0);
      check("miso_drained", miso_exp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic push_beat(input int b, input int n);
    ev_t e;
    e.kind = K_BEAT; e.b = b; e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic push_pulse(input int kind);
    ev_t e;
    e.kind = kind; e.b = 0; e.n = 0;
    exp_q.push_back(e);
  endtask

  // Master side of mode 0: data changes with SCK low, sampled on the rise.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge sysClk);
      rd[7-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (4) @(negedge sysClk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] st, input logic [7:0] fr [16],
                           input int nfull, input int tail_bits);
    logic [7:0] rd;
    status_byte = st;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge sysClk);
    for (int k = 0; k < nfull; k++) begin
      xfer(fr[k], 8, rd);
      miso_obs.push_back(int'(rd));
      miso_exp.push_back(k == 0 ? int'(st) : 0);
    end
    if (tail_bits > 0) xfer(fr[nfull], tail_bits, rd);
    repeat (4) @(negedge sysClk);
    spi_cs_n = 1'b1;
    repeat (16) @(negedge sysClk);
  endtask

  task automatic pulse_check_reset();
    #1 rst = 1'b1;
    rst_chk = 1'b1;
    @(negedge sysClk);
    #1 rst = 1'b0;
    rst_chk = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    // Reset state while rst is held
    repeat (3) @(negedge sysClk);
    #1 rst_chk = 1'b1;
    @(negedge sysClk);
    #1 rst_chk = 1'b0;
    rst = 1'b0;
    repeat (8) @(negedge sysClk);

    // Full 9-byte frame, status A5 on MISO byte 0
    for (int i = 0; i < 9; i++) push_beat(int'(f1[i]), i);
    push_pulse(K_DONE);
    run_frame(8'hA5, f1, 9, 0);

    // CS_n rises 4 bits into byte 3
    for (int i = 0; i < 3; i++) push_beat(int'(f3[i]), i);
    push_pulse(K_ERR);
    run_frame(8'h5A, f3, 3, 4);

    // 10 bytes: overrun on the 10th, nothing at CS_n rise
    for (int i = 0; i < 9; i++) push_beat(int'(f4[i]), i);
    push_pulse(K_ERR);
    run_frame(8'h00, f4, 10, 0);

    // Short 5-byte frame
    for (int i = 0; i < 5; i++) push_beat(int'(f5[i]), i);
    push_pulse(K_ERR);
    run_frame(8'h3C, f5, 5, 0);

    // Reset during byte 2, stray SCK with CS_n still low, then a clean frame
    push_beat(8'hDE, 0);
    push_beat(8'hAD, 1);
    status_byte = 8'h96;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge sysClk);
    xfer(8'hDE, 8, rd);
    miso_obs.push_back(int'(rd));
    miso_exp.push_back(8'h96);
    xfer(8'hAD, 8, rd);
    miso_obs.push_back(int'(rd));
    miso_exp.push_back(0);
    xfer(8'hBE, 4, rd);
    pulse_check_reset();
    xfer(8'hE0, 4, rd);
    xfer(8'h77, 8, rd);
    repeat (4) @(negedge sysClk);
    spi_cs_n = 1'b1;
    repeat (16) @(negedge sysClk);
    for (int i = 0; i < 9; i++) push_beat(int'(f1[i]), i);
    push_pulse(K_DONE);
    run_frame(8'h69, f1, 9, 0);

    repeat (8) @(negedge sysClk);
    #1 end_req = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
